// File: rtl/md5_pkg.sv
// md5_pkg: shared constants, chaining init values and padder state
// encoding for the MD5 message front end.
package md5_pkg;

    localparam int MD5_BLOCK_BITS  = 512;
    localparam int MD5_BLOCK_BYTES = 64;
    localparam int MD5_LEN_OFS     = 56;
    localparam int MD5_PTR_W       = 7;

    localparam logic [7:0] MD5_PAD_BYTE = 8'h80;

    // Chaining values loaded when a block arrives with out_first set.
    localparam logic [31:0] MD5_A0 = 32'h67452301;
    localparam logic [31:0] MD5_B0 = 32'hefcdab89;
    localparam logic [31:0] MD5_C0 = 32'h98badcfe;
    localparam logic [31:0] MD5_D0 = 32'h10325476;

    typedef enum logic [2:0] {
        PAD_FILL,
        PAD_EMIT_DATA,
        PAD_EMIT_SPILL,
        PAD_EMIT_SPILL_FULL,
        PAD_EMIT_FINAL
    } pad_state_e;

    // One byte placed at byte index idx of a block; idx >= 64 yields zero.
    function automatic logic [MD5_BLOCK_BITS-1:0] byte_at(
        input logic [MD5_PTR_W-1:0] idx,
        input logic [7:0]           b
    );
        return MD5_BLOCK_BITS'(b) << {idx, 3'b000};
    endfunction

endpackage

// File: rtl/md5_byte_packer.sv
// md5_byte_packer: merges one input beat into the 512-bit block buffer
// at byte offset ptr using a masked write and returns the advanced ptr.
// Ports: blk_in/blk_out block buffer, ptr/ptr_out byte offset,
//        data/nbytes the beat (lowest byte first, nbytes valid).
module md5_byte_packer
    import md5_pkg::*;
#(
    parameter int IN_BYTES = 4
) (
    input  logic [MD5_BLOCK_BITS-1:0]   blk_in,
    input  logic [MD5_PTR_W-1:0]        ptr,
    input  logic [8*IN_BYTES-1:0]       data,
    input  logic [$clog2(IN_BYTES):0]   nbytes,
    output logic [MD5_BLOCK_BITS-1:0]   blk_out,
    output logic [MD5_PTR_W-1:0]        ptr_out
);

    logic [8*IN_BYTES-1:0]     lane_mask;
    logic [MD5_BLOCK_BITS-1:0] wmask;
    logic [MD5_BLOCK_BITS-1:0] wdata;

    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < IN_BYTES; k++) begin
            if (k < int'(nbytes)) begin
                lane_mask[8*k +: 8] = 8'hff;
            end
        end
        wmask   = MD5_BLOCK_BITS'(lane_mask) << {ptr, 3'b000};
        wdata   = MD5_BLOCK_BITS'(data & lane_mask) << {ptr, 3'b000};
        blk_out = (blk_in & ~wmask) | wdata;
        ptr_out = ptr + MD5_PTR_W'(nbytes);
    end

endmodule

// File: rtl/md5_msg_padder.sv
// md5_msg_padder: packs a byte stream into 512-bit MD5 blocks, appends
// 0x80, zero fill and the 64-bit little-endian bit length.
// Ports: clk, reset_n (async, active low); in_valid/in_ready/in_data/
//   in_nbytes/in_last input beats; out_valid/out_ready/out_chunk/
//   out_first/out_last output blocks. Define MD5_PAD_ABORT_EN to add
//   the in_abort input that discards the message in progress.
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int IN_BYTES = 4,
    parameter int LEN_W    = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [8*IN_BYTES-1:0]       in_data,
    input  logic [$clog2(IN_BYTES):0]   in_nbytes,
    input  logic                        in_last,
`ifdef MD5_PAD_ABORT_EN
    input  logic                        in_abort,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MD5_BLOCK_BITS-1:0]   out_chunk,
    output logic                        out_first,
    output logic                        out_last
);

    localparam int LEN_BITS = MD5_BLOCK_BITS - 8 * MD5_LEN_OFS;

    pad_state_e                state;
    logic [MD5_PTR_W-1:0]      ptr;
    logic [LEN_W-1:0]          cnt;
    logic                      first_q;
    logic [MD5_BLOCK_BITS-1:0] blk;

    logic [MD5_BLOCK_BITS-1:0] blk_pk;
    logic [MD5_PTR_W-1:0]      ptr_pk;
    logic [LEN_W-1:0]          cnt_nx;
    logic [MD5_BLOCK_BITS-1:0] pad_p;
    logic [MD5_BLOCK_BITS-1:0] len_fin;
    logic [MD5_BLOCK_BITS-1:0] len_cur;
    logic                      hs;

    // Bit length = byte count * 8, truncated to the 64-bit field.
    function automatic logic [LEN_BITS-1:0] bit_len(
        input logic [LEN_W-1:0] c
    );
        logic [LEN_W+LEN_BITS-1:0] w;
        w = {{LEN_BITS{1'b0}}, c} << 3;
        return w[LEN_BITS-1:0];
    endfunction

    md5_byte_packer #(
        .IN_BYTES (IN_BYTES)
    ) u_packer (
        .blk_in  (blk),
        .ptr     (ptr),
        .data    (in_data),
        .nbytes  (in_nbytes),
        .blk_out (blk_pk),
        .ptr_out (ptr_pk)
    );

    assign cnt_nx    = cnt + LEN_W'(in_nbytes);
    assign pad_p     = byte_at(ptr_pk, MD5_PAD_BYTE);
    assign len_fin   = {bit_len(cnt_nx), {(8*MD5_LEN_OFS){1'b0}}};
    assign len_cur   = {bit_len(cnt), {(8*MD5_LEN_OFS){1'b0}}};
    assign hs        = out_valid & out_ready;
    assign in_ready  = (state == PAD_FILL);
    // The buffer only holds message/pad bytes, zero elsewhere, so it
    // doubles as the output register.
    assign out_chunk = blk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PAD_FILL;
            ptr       <= '0;
            cnt       <= '0;
            first_q   <= 1'b1;
            blk       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
`ifdef MD5_PAD_ABORT_EN
        else if (in_abort) begin
            state     <= PAD_FILL;
            ptr       <= '0;
            cnt       <= '0;
            first_q   <= 1'b1;
            blk       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
`endif
        else begin
            unique case (state)
                PAD_FILL: begin
                    if (in_valid) begin
                        cnt <= cnt_nx;
                        ptr <= ptr_pk;
                        if (in_last) begin
                            out_valid <= 1'b1;
                            out_first <= first_q;
                            if (ptr_pk < MD5_PTR_W'(MD5_LEN_OFS)) begin
                                // Pad byte and length fit after the data.
                                blk      <= blk_pk | pad_p | len_fin;
                                out_last <= 1'b1;
                                state    <= PAD_EMIT_FINAL;
                            end else if (ptr_pk ==
                                         MD5_PTR_W'(MD5_BLOCK_BYTES)) begin
                                blk      <= blk_pk;
                                out_last <= 1'b0;
                                state    <= PAD_EMIT_SPILL_FULL;
                            end else begin
                                blk      <= blk_pk | pad_p;
                                out_last <= 1'b0;
                                state    <= PAD_EMIT_SPILL;
                            end
                        end else begin
                            blk <= blk_pk;
                            if (ptr_pk == MD5_PTR_W'(MD5_BLOCK_BYTES)) begin
                                out_valid <= 1'b1;
                                out_first <= first_q;
                                out_last  <= 1'b0;
                                state     <= PAD_EMIT_DATA;
                            end
                        end
                    end
                end
                PAD_EMIT_DATA: begin
                    if (hs) begin
                        blk       <= '0;
                        ptr       <= '0;
                        first_q   <= 1'b0;
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        state     <= PAD_FILL;
                    end
                end
                PAD_EMIT_SPILL: begin
                    // Trailer block: zeros plus length; stays valid.
                    if (hs) begin
                        blk       <= len_cur;
                        first_q   <= 1'b0;
                        out_first <= 1'b0;
                        out_last  <= 1'b1;
                        state     <= PAD_EMIT_FINAL;
                    end
                end
                PAD_EMIT_SPILL_FULL: begin
                    if (hs) begin
                        blk       <= len_cur | byte_at('0, MD5_PAD_BYTE);
                        first_q   <= 1'b0;
                        out_first <= 1'b0;
                        out_last  <= 1'b1;
                        state     <= PAD_EMIT_FINAL;
                    end
                end
                PAD_EMIT_FINAL: begin
                    if (hs) begin
                        blk       <= '0;
                        ptr       <= '0;
                        cnt       <= '0;
                        first_q   <= 1'b1;
                        out_valid <= 1'b0;
                        out_first <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= PAD_FILL;
                    end
                end
                default: begin
                    state <= PAD_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb_md5_msg_padder: table-driven messages checked against a reference
// MD5 padding model through a block scoreboard, plus corner sequences.
module tb_md5_msg_padder;

    localparam int IB = 4;

    typedef struct {
        logic [511:0] chunk;
        bit           first;
        bit           last;
    } blk_t;

    typedef struct {
        string       s;
        int          len;
        int          nblk;
        logic [63:0] lenf;
    } vec_t;

    typedef byte bq_t[$];

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [8*IB-1:0]  in_data;
    logic [2:0]       in_nbytes;
    logic             in_last;
    logic             in_abort;
    logic             out_valid;
    logic             out_ready;
    logic [511:0]     out_chunk;
    logic             out_first;
    logic             out_last;

    int           n_cmp = 0;
    int           n_err = 0;
    int           ready_mode = 0;
    int           blk_count = 0;
    logic [63:0]  last_len = '0;
    logic [511:0] last_chunk = '0;
    blk_t         sb[$];
    vec_t         tv[11];

    md5_msg_padder #(
        .IN_BYTES (IB),
        .LEN_W    (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
`ifdef MD5_PAD_ABORT_EN
        .in_abort  (in_abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chunk (out_chunk),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bq_t mk(input string s, input int len);
        bq_t m;
        if (s.len() > 0) begin
            for (int i = 0; i < s.len(); i++) m.push_back(byte'(s[i]));
        end else begin
            for (int i = 0; i < len; i++) m.push_back(byte'(i * 7 + len));
        end
        return m;
    endfunction

    // Reference padding: append 0x80, zero to 56 mod 64, 8-byte LE length.
    function automatic void push_model(input bq_t m);
        bq_t         p;
        logic [63:0] bl;
        int          nb;
        blk_t        e;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 0; k < 8; k++) p.push_back(byte'(bl[8*k +: 8]));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.chunk = '0;
            for (int i = 0; i < 64; i++) e.chunk[8*i +: 8] = p[64*b + i];
            e.first = (b == 0);
            e.last  = (b == nb - 1);
            sb.push_back(e);
        end
    endfunction

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got in_ready=0 want 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input bq_t m, input bit with_last);
        int n = m.size();
        int i = 0;
        int nb;
        do begin
            nb = (n - i >= IB) ? IB : n - i;
            in_data = '0;
            for (int k = 0; k < nb; k++) in_data[8*k +: 8] = m[i + k];
            in_nbytes = 3'(nb);
            in_last   = with_last && (n - i <= IB);
            in_valid  = 1'b1;
            wait_accept();
            i += nb;
        end while (i < n);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d blocks pending want 0",
                     sb.size());
            sb.delete();
        end
        #1;
    endtask

    // Output ready generator: 0 = always, 1 = random, 2 = test-driven.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard: every accepted block is compared with the model.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_block: got %h want none", out_chunk);
            end else begin
                blk_t e;
                e = sb.pop_front();
                chk("chunk", out_chunk, e.chunk);
                chk("first", 512'(out_first), 512'(e.first));
                chk("last", 512'(out_last), 512'(e.last));
                blk_count++;
                last_chunk = out_chunk;
                if (out_last) last_len = out_chunk[511:448];
            end
        end
    end

    initial begin
        bq_t m;
        tv[0]  = '{s: "", len: 0, nblk: 1, lenf: 64'h0};
        tv[1]  = '{s: "A", len: 1, nblk: 1, lenf: 64'h8};
        tv[2]  = '{s: "The quick brown fox jumps over the lazy dog",
                   len: 43, nblk: 1, lenf: 64'h158};
        tv[3]  = '{s: "", len: 55, nblk: 1, lenf: 64'h1b8};
        tv[4]  = '{s: "", len: 56, nblk: 2, lenf: 64'h1c0};
        tv[5]  = '{s: "", len: 63, nblk: 2, lenf: 64'h1f8};
        tv[6]  = '{s: "", len: 64, nblk: 2, lenf: 64'h200};
        tv[7]  = '{s: "", len: 65, nblk: 2, lenf: 64'h208};
        tv[8]  = '{s: "", len: 119, nblk: 2, lenf: 64'h3b8};
        tv[9]  = '{s: "", len: 120, nblk: 3, lenf: 64'h3c0};
        tv[10] = '{s: "", len: 128, nblk: 3, lenf: 64'h400};

        in_valid  = 1'b0;
        in_data   = '0;
        in_nbytes = '0;
        in_last   = 1'b0;
        in_abort  = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_chunk", out_chunk, 512'(0));
        chk("rst_out_first", 512'(out_first), 512'(0));
        chk("rst_out_last", 512'(out_last), 512'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Empty message: block valid the cycle after the beat.
        m = mk("", 0);
        push_model(m);
        send_msg(m, 1'b1);
        chk("latency_valid", 512'(out_valid), 512'(1));
        chk("empty_first", 512'(out_first), 512'(1));
        chk("empty_last", 512'(out_last), 512'(1));
        drain();

        foreach (tv[i]) begin
            ready_mode = i % 2;
            blk_count  = 0;
            m = mk(tv[i].s, tv[i].len);
            push_model(m);
            send_msg(m, 1'b1);
            drain();
            ready_mode = 0;
            chk($sformatf("nblk_%0d", tv[i].len), 512'(blk_count),
                512'(tv[i].nblk));
            chk($sformatf("lenf_%0d", tv[i].len), 512'(last_len),
                512'(tv[i].lenf));
            if (tv[i].s == "A") begin
                chk("a_low16", 512'(last_chunk[15:0]), 512'(16'h8041));
                chk("a_len8", 512'(last_chunk[455:448]), 512'(8'h08));
            end
        end

        // 64 bytes with each block held 10 cycles; stray input ignored.
        @(posedge clk);
        #1;
        ready_mode = 2;
        out_ready  = 1'b0;
        blk_count  = 0;
        m = mk("", 64);
        push_model(m);
        send_msg(m, 1'b1);
        for (int b = 0; b < 2; b++) begin
            in_valid  = 1'b1;
            in_data   = $urandom;
            in_nbytes = 3'(IB);
            in_last   = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL hold_sb: got empty want block");
                end else begin
                    chk("hold_chunk", out_chunk, sb[0].chunk);
                end
                chk("hold_valid", 512'(out_valid), 512'(1));
                chk("hold_in_ready", 512'(in_ready), 512'(0));
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            in_last   = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        ready_mode = 0;
        drain();
        chk("hold_nblk", 512'(blk_count), 512'(2));
        chk("hold_lenf", 512'(last_len), 512'(64'h200));

        // Reset mid-message discards the partial data.
        m = mk("", 20);
        send_msg(m, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("midrst_valid", 512'(out_valid), 512'(0));
        blk_count = 0;
        m = mk("A", 1);
        push_model(m);
        send_msg(m, 1'b1);
        drain();
        chk("midrst_nblk", 512'(blk_count), 512'(1));
        chk("midrst_lenf", 512'(last_len), 512'(64'h8));

`ifdef MD5_PAD_ABORT_EN
        m = mk("", 40);
        send_msg(m, 1'b0);
        in_abort = 1'b1;
        @(posedge clk);
        #1;
        in_abort = 1'b0;
        blk_count = 0;
        m = mk("AAA", 3);
        push_model(m);
        send_msg(m, 1'b1);
        drain();
        chk("abort_nblk", 512'(blk_count), 512'(1));
        chk("abort_lenf", 512'(last_len), 512'(64'h18));
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
